// File: rtl/tri_light_feeder.sv
// rtl/tri_light_feeder.sv - triangle vertex collector and shade sequencer for the flat-shading lighting unit (optional macro LIGHT_FEEDER_DEGEN_EN)
module tri_light_feeder #(
  parameter int WII    = 8,
  parameter int WIF    = 8,
  parameter int SETTLE = 2,
  parameter int ID_W   = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 vtx_valid,
  output logic                 vtx_ready,
  input  logic [WII+WIF-1:0]   vtx_x,
  input  logic [WII+WIF-1:0]   vtx_y,
  input  logic [WII+WIF-1:0]   vtx_z,
  output logic [WII+WIF-1:0]   inax,
  output logic [WII+WIF-1:0]   inay,
  output logic [WII+WIF-1:0]   inaz,
  output logic [WII+WIF-1:0]   inbx,
  output logic [WII+WIF-1:0]   inby,
  output logic [WII+WIF-1:0]   inbz,
  output logic [WII+WIF-1:0]   incx,
  output logic [WII+WIF-1:0]   incy,
  output logic [WII+WIF-1:0]   incz,
  input  logic [5:0]           shade_in,
  output logic                 shd_valid,
  input  logic                 shd_ready,
  output logic [5:0]           shd_value,
  output logic [ID_W-1:0]      shd_index,
  output logic                 shd_degen,
  output logic                 busy
);

  localparam int W = WII + WIF;
  localparam logic [3:0] SCNT_INIT = 4'(SETTLE - 1);
  localparam logic [5:0] SHADE_AMBIENT = 6'd8;

  typedef enum logic [1:0] {ST_COLLECT, ST_SETTLE, ST_OUT} state_t;

  state_t     state, state_nx;
  logic [1:0] vcnt;
  logic [3:0] scnt;
  logic       accept;
  logic       last_beat;
  logic       sample;
  logic       fire;
  logic       degen_hit;

`ifdef LIGHT_FEEDER_DEGEN_EN
  logic [3*W-1:0] va, vb, vc;
  logic           degen_r;
  assign va = {inax, inay, inaz};
  assign vb = {inbx, inby, inbz};
  assign vc = {vtx_x, vtx_y, vtx_z};
  assign degen_hit = (vc == va) || (vc == vb) || (va == vb);
  assign shd_degen = degen_r;

  // Degenerate flag: set on a shortcut triangle, cleared on a settled sample
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      degen_r <= 1'b0;
    end else if (sample) begin
      degen_r <= 1'b0;
    end else if (last_beat && degen_hit) begin
      degen_r <= 1'b1;
    end
  end
`else
  assign degen_hit = 1'b0;
  assign shd_degen = 1'b0;
`endif

  assign last_beat = accept && (vcnt == 2'd2);
  assign busy      = !((state == ST_COLLECT) && (vcnt == 2'd0));

  // Next-state and handshake decode; ready/valid depend on state only
  always_comb begin
    state_nx  = state;
    vtx_ready = 1'b0;
    shd_valid = 1'b0;
    accept    = 1'b0;
    sample    = 1'b0;
    fire      = 1'b0;
    case (state)
      ST_COLLECT: begin
        vtx_ready = 1'b1;
        accept    = vtx_valid;
        if (vtx_valid && (vcnt == 2'd2)) begin
          state_nx = degen_hit ? ST_OUT : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (scnt == 4'd0) begin
          sample   = 1'b1;
          state_nx = ST_OUT;
        end
      end
      ST_OUT: begin
        shd_valid = 1'b1;
        if (shd_ready) begin
          fire     = 1'b1;
          state_nx = ST_COLLECT;
        end
      end
      default: state_nx = ST_COLLECT;
    endcase
  end

  // State register plus vertex and settle counters
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= ST_COLLECT;
      vcnt  <= 2'd0;
      scnt  <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vcnt <= (vcnt == 2'd2) ? 2'd0 : vcnt + 2'd1;
      end
      if (last_beat) begin
        scnt <= SCNT_INIT;
      end else if ((state == ST_SETTLE) && (scnt != 4'd0)) begin
        scnt <= scnt - 4'd1;
      end
    end
  end

  // Vertex slots: only accepted beats write, so A/B/C hold across SETTLE/OUT
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      {inax, inay, inaz} <= '0;
      {inbx, inby, inbz} <= '0;
      {incx, incy, incz} <= '0;
    end else if (accept) begin
      case (vcnt)
        2'd0:    {inax, inay, inaz} <= {vtx_x, vtx_y, vtx_z};
        2'd1:    {inbx, inby, inbz} <= {vtx_x, vtx_y, vtx_z};
        default: {incx, incy, incz} <= {vtx_x, vtx_y, vtx_z};
      endcase
    end
  end

  // Result capture and wrapping triangle index
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      shd_value <= 6'd0;
      shd_index <= '0;
    end else begin
      if (sample) begin
        shd_value <= shade_in;
      end else if (last_beat && degen_hit) begin
        shd_value <= SHADE_AMBIENT;
      end
      if (fire) begin
        shd_index <= shd_index + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tri_light_feeder.sv
// tb/tb_tri_light_feeder.sv - directed self-checking bench for tri_light_feeder
module tb_tri_light_feeder;

  localparam int W    = 16;
  localparam int ID_W = 2;

  logic            Clk;
  logic            Reset;
  logic            vtx_valid;
  logic            vtx_ready;
  logic [W-1:0]    vtx_x, vtx_y, vtx_z;
  logic [W-1:0]    inax, inay, inaz, inbx, inby, inbz, incx, incy, incz;
  logic [5:0]      shade_in;
  logic            shd_valid;
  logic            shd_ready;
  logic [5:0]      shd_value;
  logic [ID_W-1:0] shd_index;
  logic            shd_degen;
  logic            busy;

  int n_checks = 0;
  int n_fails  = 0;

  tri_light_feeder #(.WII(8), .WIF(8), .SETTLE(2), .ID_W(ID_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
    .inax(inax), .inay(inay), .inaz(inaz),
    .inbx(inbx), .inby(inby), .inbz(inbz),
    .incx(incx), .incy(incy), .incz(incz),
    .shade_in(shade_in),
    .shd_valid(shd_valid), .shd_ready(shd_ready),
    .shd_value(shd_value), .shd_index(shd_index),
    .shd_degen(shd_degen), .busy(busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic send_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    logic rdy;
    logic done;
    done = 1'b0;
    vtx_valid = 1'b1;
    vtx_x = x; vtx_y = y; vtx_z = z;
    for (int i = 0; i < 20 && !done; i++) begin
      rdy = vtx_ready;
      tick();
      done = rdy;
    end
    vtx_valid = 1'b0;
    chk("beat_accepted", done, 1'b1);
  endtask

  task automatic handshake();
    shd_ready = 1'b1;
    tick();
    shd_ready = 1'b0;
  endtask

  initial begin
    int b;
    logic rdy;
    int m;
    Reset = 1'b0; vtx_valid = 1'b0; vtx_x = '0; vtx_y = '0; vtx_z = '0;
    shade_in = 6'd0; shd_ready = 1'b0;
    tick(); tick();
    chk("rst_shd_valid", shd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_shd_index", shd_index, 0);
    chk("rst_shd_value", shd_value, 0);
    Reset = 1'b1;

    // single triangle, SETTLE=2
    shade_in = 6'd40;
    send_beat(16'h0000, 16'h0000, 16'h0000);
    send_beat(16'h0100, 16'h0000, 16'h0000);
    send_beat(16'h0000, 16'h0100, 16'h0000);
    chk("t1_valid_n", shd_valid, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_valid_n1", shd_valid, 0);
    tick();
    chk("t1_valid_n2", shd_valid, 1);
    chk("t1_value", shd_value, 40);
    chk("t1_index", shd_index, 0);
    chk("t1_degen", shd_degen, 0);
    chk("t1_inbx", inbx, 16'h0100);
    chk("t1_incy", incy, 16'h0100);

    // hold result with downstream stalled while upstream keeps offering
    for (int i = 0; i < 10; i++) begin
      vtx_valid = i[0];
      vtx_x = 16'(i * 7 + 3);
      shade_in = 6'(i);
      tick();
      chk("hold_valid", shd_valid, 1);
      chk("hold_value", shd_value, 40);
      chk("hold_vtx_ready", vtx_ready, 0);
      chk("hold_inax", inax, 16'h0000);
      chk("hold_inbx", inbx, 16'h0100);
      chk("hold_incx", incx, 16'h0000);
    end
    vtx_valid = 1'b0;
    handshake();
    chk("hs_valid", shd_valid, 0);
    chk("hs_vtx_ready", vtx_ready, 1);
    chk("hs_index", shd_index, 1);
    chk("hs_busy", busy, 0);

    // reset, then 5 back-to-back triangles: 6-cycle period, index 0,1,2,3,0
    Reset = 1'b0; tick(); Reset = 1'b1;
    chk("rst2_index", shd_index, 0);
    b = 0;
    shd_ready = 1'b1;
    vtx_valid = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      vtx_x = 16'(b * 16 + 1);
      vtx_y = 16'(b * 3 + 2);
      vtx_z = 16'(b);
      shade_in = 6'(k);
      rdy = vtx_ready;
      tick();
      if (rdy) b++;
      m = k % 6;
      chk("str_valid", shd_valid, (m == 5));
      chk("str_vtx_ready", vtx_ready, !(m == 3 || m == 4 || m == 5));
      if (m == 5) begin
        chk("str_value", shd_value, 6'(k));
        chk("str_index", shd_index, (k / 6) % 4);
      end
    end
    vtx_valid = 1'b0;
    shd_ready = 1'b0;
    chk("str_beats", b, 15);

    // reset after vertex B discards the partial triangle
    send_beat(16'h0011, 16'h0022, 16'h0033);
    send_beat(16'h0044, 16'h0055, 16'h0066);
    chk("mid_busy", busy, 1);
    Reset = 1'b0;
    tick();
    chk("mrst_inax", inax, 0);
    chk("mrst_inbx", inbx, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_index", shd_index, 0);
    chk("mrst_valid", shd_valid, 0);
    chk("mrst_degen", shd_degen, 0);
    Reset = 1'b1;
    shade_in = 6'd17;
    send_beat(16'd5, 16'd6, 16'd7);
    chk("post_slot_a", inax, 5);
    chk("post_slot_b", inbx, 0);
    send_beat(16'd8, 16'd9, 16'd10);
    send_beat(16'd11, 16'd12, 16'd13);
    chk("post_incx", incx, 11);
    tick(); tick();
    chk("post_valid", shd_valid, 1);
    chk("post_value", shd_value, 17);
    chk("post_index", shd_index, 0);
    handshake();

    // C equal to A
    shade_in = 6'd33;
    send_beat(16'd3, 16'd3, 16'd3);
    send_beat(16'd4, 16'd4, 16'd4);
    send_beat(16'd3, 16'd3, 16'd3);
`ifdef LIGHT_FEEDER_DEGEN_EN
    chk("dg_valid", shd_valid, 1);
    chk("dg_value", shd_value, 8);
    chk("dg_degen", shd_degen, 1);
`else
    chk("dg_valid_n", shd_valid, 0);
    tick();
    chk("dg_valid_n1", shd_valid, 0);
    tick();
    chk("dg_valid_n2", shd_valid, 1);
    chk("dg_value", shd_value, 33);
    chk("dg_degen", shd_degen, 0);
`endif
    chk("dg_index", shd_index, 1);
    handshake();
    chk("dg_done", shd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
